// File: rtl/audio_i2s_tx.sv
// I2S transmitter: sample-pair FIFO, fractional MCLK generator, MSB-first serialiser.
// Build option AUDIO_I2S_HOLD_ON_UNDERRUN_EN repeats the last popped frame on underrun.
module audio_i2s_tx #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned MCLK_INC     = 245760,
  parameter int unsigned MCLK_MOD     = 742500,
  parameter int unsigned ACC_WIDTH    = 22
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [SAMPLE_WIDTH-1:0]       sample_l,
  input  logic [SAMPLE_WIDTH-1:0]       sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          audio_mclk,
  output logic                          audio_lrck,
  output logic                          audio_dac
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [ACC_WIDTH-1:0] AccInc = ACC_WIDTH'(MCLK_INC);
  localparam logic [ACC_WIDTH-1:0] AccMod = ACC_WIDTH'(MCLK_MOD);
  localparam logic [LvlW-1:0]      LvlFull = LvlW'(FIFO_DEPTH);

`ifdef AUDIO_I2S_HOLD_ON_UNDERRUN_EN
  localparam bit HoldOnUnderrun = 1'b1;
`else
  localparam bit HoldOnUnderrun = 1'b0;
`endif

  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    mclk_q, mclk_d;
  logic [1:0]              div_q, div_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic                    lrck_q, lrck_d;
  logic                    dac_q, dac_d;
  logic [31:0]             word_l_q, word_l_d;
  logic [31:0]             word_r_q, word_r_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]         level_q, level_d;
  logic                    ready_q;
  logic                    underrun_q, underrun_d;

  logic [SAMPLE_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];

  logic                    mclk_tick;
  logic                    mclk_rise;
  logic                    sclk_fall;
  logic                    frame_start;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic [31:0]             pop_word_l;
  logic [31:0]             pop_word_r;
  logic [31:0]             slot_word;
  logic [4:0]              bit_idx;

  // Fractional divider: toggles MCLK on average MCLK_INC/MCLK_MOD times per clk.
  assign mclk_tick = (acc_q >= AccMod);
  assign mclk_rise = mclk_tick && !mclk_q;
  assign sclk_fall = mclk_rise && (div_q == 2'd3);

  always_comb begin
    acc_d  = acc_q + AccInc;
    mclk_d = mclk_q;
    if (mclk_tick) begin
      acc_d  = acc_q - AccMod + AccInc;
      mclk_d = ~mclk_q;
    end
  end

  assign div_d = mclk_rise ? div_q + 2'd1 : div_q;

  assign frame_start = sclk_fall && (bit_cnt_q == 5'd31) && lrck_q;
  assign fifo_empty  = (level_q == '0);
  assign push        = sample_valid && ready_q;
  assign pop         = frame_start && !fifo_empty;

  assign pop_word_l = 32'(mem_l[rd_ptr_q]) << (32 - SAMPLE_WIDTH);
  assign pop_word_r = 32'(mem_r[rd_ptr_q]) << (32 - SAMPLE_WIDTH);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (frame_start && fifo_empty) underrun_d = 1'b1;
  end

  // Next position p carries word bit (32-p) mod 32; at p=0 lrck_q still selects the
  // slot that is ending, which yields the one-bit I2S delay.
  assign slot_word = lrck_q ? word_r_q : word_l_q;
  assign bit_idx   = ~bit_cnt_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    dac_d     = dac_q;
    word_l_d  = word_l_q;
    word_r_d  = word_r_q;
    if (sclk_fall) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      dac_d     = slot_word[bit_idx];
      if (bit_cnt_q == 5'd31) lrck_d = ~lrck_q;
    end
    if (pop) begin
      word_l_d = pop_word_l;
      word_r_d = pop_word_r;
    end else if (frame_start && !HoldOnUnderrun) begin
      word_l_d = '0;
      word_r_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      mclk_q     <= 1'b0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      lrck_q     <= 1'b0;
      dac_q      <= 1'b0;
      word_l_q   <= '0;
      word_r_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      mclk_q     <= mclk_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dac_q      <= dac_d;
      word_l_q   <= word_l_d;
      word_r_q   <= word_r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= (level_d != LvlFull);
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset; level and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wr_ptr_q] <= sample_l;
      mem_r[wr_ptr_q] <= sample_r;
    end
  end

  assign sample_ready = ready_q;
  assign fifo_level   = level_q;
  assign underrun     = underrun_q;
  assign audio_mclk   = mclk_q;
  assign audio_lrck   = lrck_q;
  assign audio_dac    = dac_q;

endmodule
